// File: rtl/ahb_sram_slave.sv
// AHB SRAM responder with byte-lane writes, wait states and ERROR response.
// Backs a word-organised register array of 2**ADDR_WIDTH words.
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic [1:0]  HRESP
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [15:0] HI_MASK = 16'(32'hFFFF << (ADDR_WIDTH + 2));

  logic [31:0] mem [DEPTH];

  state_t                state, state_n;
  logic [1:0]            cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [3:0]            be_q, be;
  logic                  wr_q;
  logic                  open, sel, bad;
  logic                  unused;

  assign unused = ^{HADDR[31:16], HTRANS[0]};

  assign open = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign sel  = open && HSEL && HREADY && HTRANS[1];

  always_comb begin
    bad = 1'b0;
    be  = 4'b0000;
    unique case (1'b1)
      (HSIZE == 3'b000): be = 4'b0001 << HADDR[1:0];
      (HSIZE == 3'b001): begin
        be  = HADDR[1] ? 4'b1100 : 4'b0011;
        bad = HADDR[0];
      end
      (HSIZE == 3'b010): begin
        be  = 4'b1111;
        bad = |HADDR[1:0];
      end
      default: bad = 1'b1;
    endcase
    if (|(HADDR[15:0] & HI_MASK)) bad = 1'b1;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      S_WAIT: begin
        cnt_n = cnt - 2'd1;
        if (cnt == 2'd1) state_n = S_DATA;
      end
      S_ERR1: state_n = S_ERR2;
      default: begin
        state_n = S_IDLE;
        if (sel) begin
          if (bad) begin
            state_n = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_n = S_DATA;
          end else begin
            state_n = S_WAIT;
            cnt_n   = 2'(WAIT_STATES);
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= S_IDLE;
      cnt   <= 2'd0;
      idx_q <= '0;
      be_q  <= 4'b0000;
      wr_q  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (sel && !bad) begin
        idx_q <= HADDR[ADDR_WIDTH+1:2];
        be_q  <= be;
        wr_q  <= HWRITE;
      end
    end
  end

  // Commit lands on the DATA edge, so a following read already sees it.
  always_ff @(posedge HCLK) begin
    if (state == S_DATA && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HREADYOUT = !((state == S_WAIT) || (state == S_ERR1));
  assign HRESP     = {1'b0, (state == S_ERR1) || (state == S_ERR2)};
  assign HRDATA    = (state == S_DATA && !wr_q) ? mem[idx_q] : 32'h0;

endmodule
